// File: rtl/ffs.sv
// ---------------------------------------------------------------------------
// ffs : parameterised find-first-set (priority encoder)
//
// Reports the index of the first set bit of a WIDTH-bit vector, searched
// from the LSB (MSB_FIRST = 0) or from the MSB (MSB_FIRST = 1). The search
// is a balanced binary reduction tree of OUT_W levels, so the combinational
// depth grows with log2(WIDTH). The root result is registered once, which
// gives one cycle of latency and a new result every cycle.
//
// Parameters
//   WIDTH     : input vector width, any value >= 1
//   MSB_FIRST : 0 = lowest set index wins, 1 = highest set index wins
//
// Ports
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset, clears valid/out
//   in    : vector to search, sampled every rising edge
//   valid : registered, 1 when the sampled vector had any bit set
//   out   : registered, index of the first set bit (0 when nothing set)
// ---------------------------------------------------------------------------
module ffs #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0,
  localparam int OUT_W    = (WIDTH <= 1) ? 1 : $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic             valid,
  output logic [OUT_W-1:0] out
);

  // Padded width is the next power of two; WIDTH = 1 still builds one level.
  localparam int P = 1 << OUT_W;

  logic [P-1:0]     w_padded;
  logic             w_rootV;
  logic [OUT_W-1:0] w_rootIdx;
  logic             r_valid;
  logic [OUT_W-1:0] r_out;

  // Upper padding bits are tied to zero so they can never win the search.
  always_comb begin
    w_padded            = '0;
    w_padded[WIDTH-1:0] = in;
  end

  // Level l holds P>>l nodes, each with a valid flag and an l-bit index
  // relative to the start of the node's span. Level 1 is built straight
  // from pairs of input bits; every further level merges two child nodes
  // and prepends one bit saying which child supplied the index.
  for (genvar l = 1; l <= OUT_W; l++) begin : g_lvl
    localparam int N = P >> l;
    logic [N-1:0]   w_v;
    logic [N*l-1:0] w_idx;

    if (l == 1) begin : g_leaf
      for (genvar j = 0; j < N; j++) begin : g_node
        assign w_v[j] = w_padded[2*j] | w_padded[2*j+1];
        // When neither bit is set the index is don't-care; valid masks it.
        if (MSB_FIRST != 0) begin : g_msb
          assign w_idx[j] = w_padded[2*j+1];
        end else begin : g_lsb
          assign w_idx[j] = ~w_padded[2*j];
        end
      end
    end else begin : g_merge
      for (genvar j = 0; j < N; j++) begin : g_node
        logic         w_loV;
        logic         w_hiV;
        logic [l-2:0] w_loIdx;
        logic [l-2:0] w_hiIdx;

        assign w_loV   = g_lvl[l-1].w_v[2*j];
        assign w_hiV   = g_lvl[l-1].w_v[2*j+1];
        assign w_loIdx = g_lvl[l-1].w_idx[(2*j)*(l-1) +: (l-1)];
        assign w_hiIdx = g_lvl[l-1].w_idx[(2*j+1)*(l-1) +: (l-1)];
        assign w_v[j]  = w_loV | w_hiV;

        // The preferred child is checked first; the other is the fallback.
        if (MSB_FIRST != 0) begin : g_msb
          assign w_idx[j*l +: l] = w_hiV ? {1'b1, w_hiIdx} : {1'b0, w_loIdx};
        end else begin : g_lsb
          assign w_idx[j*l +: l] = w_loV ? {1'b0, w_loIdx} : {1'b1, w_hiIdx};
        end
      end
    end
  end

  assign w_rootV   = g_lvl[OUT_W].w_v[0];
  assign w_rootIdx = g_lvl[OUT_W].w_idx[OUT_W-1:0];

  // Output register. The index is forced to zero when nothing was set so
  // the don't-care path through the tree never reaches the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_out   <= '0;
    end else begin
      r_valid <= w_rootV;
      r_out   <= w_rootV ? w_rootIdx : '0;
    end
  end

  assign valid = r_valid;
  assign out   = r_out;

endmodule

// File: tb/tb_ffs.sv
// ---------------------------------------------------------------------------
// tb_ffs : directed and sweep bench for ffs
//
// Four instances share one clock and reset: WIDTH=8 LSB-first, WIDTH=8
// MSB-first, WIDTH=5 LSB-first and WIDTH=1. Inputs change on the falling
// edge; outputs are checked 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_ffs;

  logic       clk;
  logic       rst_n;
  logic [7:0] in8;
  logic [4:0] in5;
  logic [0:0] in1;

  logic       valid8L;
  logic [2:0] out8L;
  logic       valid8M;
  logic [2:0] out8M;
  logic       valid5;
  logic [2:0] out5;
  logic       valid1;
  logic [0:0] out1;

  int checks;
  int errors;

  ffs #(.WIDTH(8), .MSB_FIRST(0)) dut8L (
    .clk(clk), .rst_n(rst_n), .in(in8), .valid(valid8L), .out(out8L)
  );

  ffs #(.WIDTH(8), .MSB_FIRST(1)) dut8M (
    .clk(clk), .rst_n(rst_n), .in(in8), .valid(valid8M), .out(out8M)
  );

  ffs #(.WIDTH(5), .MSB_FIRST(0)) dut5 (
    .clk(clk), .rst_n(rst_n), .in(in5), .valid(valid5), .out(out5)
  );

  ffs #(.WIDTH(1), .MSB_FIRST(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in(in1), .valid(valid1), .out(out1)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference: linear scan in the requested direction.
  function automatic int refIdx(input int v, input int w, input bit msb);
    if (msb) begin
      for (int i = w - 1; i >= 0; i--) if (v[i]) return i;
    end else begin
      for (int i = 0; i < w; i++) if (v[i]) return i;
    end
    return 0;
  endfunction

  // Single comparison point.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive new inputs on the falling edge, then move to just after the
  // next rising edge where the registered result is visible.
  task automatic applyStimulus(input logic [7:0] v8, input logic [4:0] v5, input logic v1);
    @(negedge clk);
    in8 = v8;
    in5 = v5;
    in1 = v1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    in8    = 8'hFF;
    in5    = 5'h1F;
    in1    = 1'b1;

    // Reset held across several edges with every input bit set.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_hold_valid8L", int'(valid8L), 0);
    checkOutput("rst_hold_out8L", int'(out8L), 0);
    checkOutput("rst_hold_valid8M", int'(valid8M), 0);
    checkOutput("rst_hold_out8M", int'(out8M), 0);
    checkOutput("rst_hold_valid1", int'(valid1), 0);

    // First edge after release registers the input present at that edge.
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'h00, 5'h00, 1'b0);
    checkOutput("zero_valid8L", int'(valid8L), 0);
    checkOutput("zero_out8L", int'(out8L), 0);
    checkOutput("zero_valid8M", int'(valid8M), 0);
    checkOutput("zero_out8M", int'(out8M), 0);
    checkOutput("w1_zero_valid", int'(valid1), 0);
    checkOutput("w5_zero_valid", int'(valid5), 0);

    applyStimulus(8'h01, 5'b10000, 1'b1);
    checkOutput("lsb_01_valid", int'(valid8L), 1);
    checkOutput("lsb_01_out", int'(out8L), 0);
    checkOutput("msb_01_out", int'(out8M), 0);
    checkOutput("w5_10000_valid", int'(valid5), 1);
    checkOutput("w5_10000_out", int'(out5), 4);
    checkOutput("w1_one_valid", int'(valid1), 1);
    checkOutput("w1_one_out", int'(out1), 0);

    applyStimulus(8'h80, 5'b00110, 1'b0);
    checkOutput("lsb_80_valid", int'(valid8L), 1);
    checkOutput("lsb_80_out", int'(out8L), 7);
    checkOutput("msb_80_out", int'(out8M), 7);
    checkOutput("w5_00110_out", int'(out5), 1);
    checkOutput("w1_zero_valid_b", int'(valid1), 0);
    checkOutput("w1_zero_out_b", int'(out1), 0);

    applyStimulus(8'hB4, 5'h00, 1'b0);
    checkOutput("lsb_B4_out", int'(out8L), 2);
    checkOutput("msb_B4_valid", int'(valid8M), 1);
    checkOutput("msb_B4_out", int'(out8M), 7);

    applyStimulus(8'h2C, 5'h00, 1'b0);
    checkOutput("lsb_2C_out", int'(out8L), 2);
    checkOutput("msb_2C_out", int'(out8M), 5);
    checkOutput("w5_zero_out", int'(out5), 0);

    applyStimulus(8'hFF, 5'h00, 1'b0);
    checkOutput("lsb_FF_out", int'(out8L), 0);
    checkOutput("msb_FF_out", int'(out8M), 7);
    checkOutput("msb_FF_valid", int'(valid8M), 1);

    // Asynchronous reset mid-cycle while a valid result is showing.
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid8M", int'(valid8M), 0);
    checkOutput("async_rst_out8M", int'(out8M), 0);
    checkOutput("async_rst_valid8L", int'(valid8L), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back sweep of every 8-bit value; each result is checked
    // against the model applied to the input of the previous edge.
    for (int i = 0; i < 256; i++) begin
      applyStimulus(8'(i), 5'(i), 1'(i));
      checkOutput($sformatf("sweep_valid8L_%0d", i), int'(valid8L), (i != 0) ? 1 : 0);
      checkOutput($sformatf("sweep_out8L_%0d", i), int'(out8L), refIdx(i, 8, 1'b0));
      checkOutput($sformatf("sweep_valid8M_%0d", i), int'(valid8M), (i != 0) ? 1 : 0);
      checkOutput($sformatf("sweep_out8M_%0d", i), int'(out8M), refIdx(i, 8, 1'b1));
      checkOutput($sformatf("sweep_out5_%0d", i), int'(out5), refIdx(i & 31, 5, 1'b0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
